// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolver.
//  - br_op_e      : 3-bit branch condition codes (BEQ..BGEZ)
//  - BR_OP_LENGTH : width of the condition code
//  - BHT_INIT     : reset value of every BHT counter (weakly not-taken)
//  - bht_sat_next : saturating 2-bit counter step
package branch_resolve_unit_pkg;

    localparam int BR_OP_LENGTH = 3;

    typedef enum logic [BR_OP_LENGTH-1:0] {
        BR_OP_BEQ  = 3'd0,
        BR_OP_BNE  = 3'd1,
        BR_OP_BLT  = 3'd2,
        BR_OP_BGE  = 3'd3,
        BR_OP_BLEZ = 3'd4,
        BR_OP_BGTZ = 3'd5,
        BR_OP_BLTZ = 3'd6,
        BR_OP_BGEZ = 3'd7
    } br_op_e;

    localparam logic [1:0] BHT_INIT = 2'b01;

    // Step a 2-bit counter towards taken (up) or not-taken, saturating at 3 / 0.
    function automatic logic [1:0] bht_sat_next(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        res = ctr;
        if (up && ctr != 2'b11) begin
            res = ctr + 2'd1;
        end else if (!up && ctr != 2'b00) begin
            res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// bht_2bit: array of 2-bit saturating counters.
//  clk, rst        : clock, synchronous active-high reset (all entries -> BHT_INIT)
//  rd_idx_i        : asynchronous read index
//  rd_ctr_o        : counter at rd_idx_i (value before any same-cycle update)
//  upd_en_i        : train the entry at upd_idx_i this cycle
//  upd_idx_i       : entry to train
//  upd_taken_i     : direction to train towards
// Kept in flops rather than RAM: every entry must reset in one cycle.
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [1:0]       rd_ctr_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    logic [1:0] ctr_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctr_q[gi] <= BHT_INIT;
                end else if (upd_en_i && upd_idx_i == IDX_W'(gi)) begin
                    ctr_q[gi] <= bht_sat_next(ctr_q[gi], upd_taken_i);
                end
            end
        end
    endgenerate

    assign rd_ctr_o = ctr_q[rd_idx_i];

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered EX-stage branch resolver with a 2-bit BHT.
//  clk, rst                 : clock, synchronous active-high reset
//  flush                    : squash held and incoming branch
//  in_valid/in_ready        : branch op handshake (br_op, br_unsigned, rs_data,
//                             rt_data, pc, target, pred_taken)
//  out_valid/out_ready      : resolved result handshake (taken, mispredict, redirect_pc)
//  query_pc/query_taken     : combinational IF-stage BHT lookup
// The BHT is trained with the held result when it is handed off downstream.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BR_OP_LENGTH-1:0] br_op,
    input  logic                    br_unsigned,
    input  logic [DATA_W-1:0]       rs_data,
    input  logic [DATA_W-1:0]       rt_data,
    input  logic [ADDR_W-1:0]       pc,
    input  logic [ADDR_W-1:0]       target,
    input  logic                    pred_taken,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    taken,
    output logic                    mispredict,
    output logic [ADDR_W-1:0]       redirect_pc,
    input  logic [ADDR_W-1:0]       query_pc,
    output logic                    query_taken
);

    logic              out_valid_q;
    logic              taken_q,  taken_d;
    logic              mispredict_q;
    logic [ADDR_W-1:0] redirect_q, redirect_d;
    logic [IDX_W-1:0]  idx_q;

    logic accept;
    logic train_en;
    logic rs_neg, rs_zero, lt_signed, lt_unsigned, lt_sel, eq;
    logic [1:0] query_ctr;

    // Condition evaluator; zero-compare ops always treat rs as signed.
    assign eq          = (rs_data == rt_data);
    assign lt_signed   = ($signed(rs_data) < $signed(rt_data));
    assign lt_unsigned = (rs_data < rt_data);
    assign lt_sel      = br_unsigned ? lt_unsigned : lt_signed;
    assign rs_neg      = rs_data[DATA_W-1];
    assign rs_zero     = (rs_data == '0);

    always_comb begin
        taken_d = 1'b0;
        case (br_op_e'(br_op))
            BR_OP_BEQ:  taken_d = eq;
            BR_OP_BNE:  taken_d = !eq;
            BR_OP_BLT:  taken_d = lt_sel;
            BR_OP_BGE:  taken_d = !lt_sel;
            BR_OP_BLEZ: taken_d = rs_neg || rs_zero;
            BR_OP_BGTZ: taken_d = !rs_neg && !rs_zero;
            BR_OP_BLTZ: taken_d = rs_neg;
            BR_OP_BGEZ: taken_d = !rs_neg;
            default:    taken_d = 1'b0;
        endcase
    end

    // Fall-through address wraps naturally at ADDR_W bits.
    assign redirect_d = taken_d ? target : (pc + ADDR_W'(4));

    // Handshake control
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign train_en = out_valid_q && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Payload only moves on accept, so a stalled result stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            idx_q        <= '0;
        end else if (accept) begin
            taken_q      <= taken_d;
            mispredict_q <= (taken_d != pred_taken);
            redirect_q   <= redirect_d;
            idx_q        <= pc[IDX_W+1:2];
        end
    end

    bht_2bit #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (query_pc[IDX_W+1:2]),
        .rd_ctr_o    (query_ctr),
        .upd_en_i    (train_en),
        .upd_idx_i   (idx_q),
        .upd_taken_i (taken_q)
    );

    assign query_taken = query_ctr[1];
    assign out_valid   = out_valid_q;
    assign taken       = taken_q;
    assign mispredict  = mispredict_q;
    assign redirect_pc = redirect_q;

    // Only the index bits of the lookup PC select an entry.
    logic unused_query_bits;
    assign unused_query_bits = ^{query_pc[ADDR_W-1:IDX_W+2], query_pc[1:0], query_ctr[0]};

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, br_unsigned, pred_taken;
    logic [2:0]  br_op;
    logic [31:0] rs_data, rt_data, pc, target, redirect_pc, query_pc;
    logic        out_valid, out_ready, taken, mispredict, query_taken;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .BHT_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .br_op(br_op), .br_unsigned(br_unsigned), .rs_data(rs_data), .rt_data(rt_data),
        .pc(pc), .target(target), .pred_taken(pred_taken), .out_valid(out_valid),
        .out_ready(out_ready), .taken(taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .query_pc(query_pc), .query_taken(query_taken)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int unsigned m_bht [64];
    bit          m_valid, m_taken, m_misp, model_ok;
    logic [31:0] m_redir;
    int unsigned m_idx;

    function automatic bit ref_taken(input int op, input bit uns, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            0: return sa == sb;
            1: return sa != sb;
            2: return uns ? (ua < ub) : (sa < sb);
            3: return uns ? (ua >= ub) : (sa >= sb);
            4: return sa <= 0;
            5: return sa > 0;
            6: return sa < 0;
            default: return sa >= 0;
        endcase
    endfunction

    always @(posedge clk) begin
        bit ready, hs, t;
        ready = !m_valid || out_ready;
        hs    = m_valid && out_ready && !flush;
        if (rst) begin
            m_valid = 0; m_taken = 0; m_misp = 0; m_redir = 0; m_idx = 0;
            for (int i = 0; i < 64; i++) m_bht[i] = 1;
            model_ok = 1;
        end else if (model_ok) begin
            if (hs) begin
                if (m_taken && m_bht[m_idx] < 3) m_bht[m_idx] = m_bht[m_idx] + 1;
                else if (!m_taken && m_bht[m_idx] > 0) m_bht[m_idx] = m_bht[m_idx] - 1;
            end
            if (flush) begin
                m_valid = 0;
            end else if (in_valid && ready) begin
                t       = ref_taken(int'(br_op), br_unsigned, rs_data, rt_data);
                m_valid = 1;
                m_taken = t;
                m_misp  = (t != pred_taken);
                m_redir = t ? target : pc + 32'd4;
                m_idx   = (pc / 4) % 64;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", in_ready, !m_valid || out_ready);
            chk("out_valid", out_valid, m_valid);
            chk("taken", taken, m_taken);
            chk("mispredict", mispredict, m_misp);
            chk("redirect_pc", redirect_pc, m_redir);
            chk("query_taken", query_taken, m_bht[(query_pc / 4) % 64] >= 2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int op, input bit uns, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] tg, input bit pr);
        br_op = 3'(op); br_unsigned = uns; rs_data = a; rt_data = b;
        pc = p; target = tg; pred_taken = pr;
    endtask

    // Present one op for one cycle, then drop in_valid.
    task automatic issue(input int op, input bit uns, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] tg, input bit pr);
        set_op(op, uns, a, b, p, tg, pr);
        in_valid = 1;
        cyc();
        in_valid = 0;
    endtask

    task automatic reset_pulse();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 6)) - 32'd3;
            1: return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 1; query_pc = 0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        cyc(); cyc();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_redirect", redirect_pc, 0);
        rst = 0;

        // Condition evaluation
        issue(2, 0, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h2000, 1);
        chk("blt_signed", taken, 1);
        chk("blt_signed_valid", out_valid, 1);
        issue(2, 1, 32'hFFFF_FFFF, 32'd1, 32'h1000, 32'h2000, 1);
        chk("blt_unsigned", taken, 0);
        chk("blt_unsigned_misp", mispredict, 1);
        chk("blt_unsigned_redir", redirect_pc, 32'h1004);
        issue(5, 0, 32'd0, 32'd7, 32'h1010, 32'h2000, 0);
        chk("bgtz_zero", taken, 0);
        issue(7, 0, 32'd0, 32'd0, 32'h1010, 32'h2000, 0);
        chk("bgez_zero", taken, 1);
        issue(0, 0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h100, 0);
        chk("beq_misp", mispredict, 1);
        chk("beq_redir", redirect_pc, 32'h100);
        issue(1, 0, 32'd9, 32'd9, 32'hFFFF_FFFC, 32'h100, 0);
        chk("bne_wrap_redir", redirect_pc, 32'h0);
        chk("bne_wrap_misp", mispredict, 0);
        cyc();

        // Stall for 3 cycles, then two back-to-back handshakes
        out_ready = 0;
        set_op(2, 0, 32'hFFFF_FFFF, 32'd1, 32'h1100, 32'h3000, 0);
        in_valid = 1;
        cyc();
        set_op(0, 0, 32'd1, 32'd2, 32'h1104, 32'h3000, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_taken", taken, 1);
            chk("stall_redir", redirect_pc, 32'h3000);
            cyc();
        end
        out_ready = 1;
        #1;
        chk("release_in_ready", in_ready, 1);
        cyc();
        chk("b2b_first_valid", out_valid, 1);
        chk("b2b_first_taken", taken, 0);
        set_op(7, 0, 32'd5, 32'd0, 32'h1108, 32'h3000, 1);
        cyc();
        chk("b2b_second_valid", out_valid, 1);
        chk("b2b_second_taken", taken, 1);
        in_valid = 0;
        cyc();
        chk("drain_valid", out_valid, 0);

        // BHT training at 0x40; query lands in the update cycle
        reset_pulse();
        query_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 32'd5, 32'd5, 32'h40, 32'h80, 1);
            chk("bht_update_cycle", query_taken, (i == 0) ? 0 : 1);
            cyc();
            chk("bht_after_update", query_taken, 1);
        end
        query_pc = 32'h140;
        #1;
        chk("bht_alias", query_taken, 1);
        for (int i = 0; i < 3; i++) begin
            issue(1, 0, 32'd5, 32'd5, 32'h140, 32'h80, 0);
            cyc();
            chk("bht_down", query_taken, (i == 0) ? 1 : 0);
        end

        // Flush while held: result dropped, no training
        query_pc = 32'h80;
        out_ready = 0;
        issue(0, 0, 32'd3, 32'd3, 32'h80, 32'h200, 0);
        chk("flush_held", out_valid, 1);
        flush = 1; out_ready = 1;
        cyc();
        flush = 0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_no_train", query_taken, 0);
        cyc();
        chk("flush_no_train2", query_taken, 0);

        // Reset mid-stall
        query_pc = 32'h40;
        out_ready = 0;
        issue(0, 0, 32'd3, 32'd3, 32'h40, 32'h200, 0);
        reset_pulse();
        out_ready = 1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_taken", taken, 0);
        chk("rst_query", query_taken, 0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            a           = rnd_operand();
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 24) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            br_op       = 3'($urandom_range(0, 7));
            br_unsigned = 1'($urandom_range(0, 1));
            rs_data     = a;
            rt_data     = ($urandom_range(0, 3) == 0) ? a : rnd_operand();
            pc          = ($urandom_range(0, 1) == 0) ? (32'($urandom_range(0, 15)) << 2)
                                                      : (32'($urandom) & ~32'd3);
            target      = $urandom;
            pred_taken  = 1'($urandom_range(0, 1));
            query_pc    = ($urandom_range(0, 1) == 0) ? pc : 32'($urandom);
            cyc();
        end
        rst = 0; flush = 0; in_valid = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
